xvga_timing_gen: RTL and testbench

XGA (1024x768 @ 60 Hz, 65 MHz pixel clock) raster timing generator and output aligner for the display path. Produces the hcount/vcount/hsync/vsync/blank raster that the sprite/pixel writer consumes, plus a vertical-blank update strobe. Takes the writer's pixel back after a fixed pipeline delay and drives the VGA pins with sync and blank re-aligned to that pixel.

---
 rtl/xvga_timing_gen.sv | 167 ++++++++++++++++
 tb/tb_xvga_timing_gen.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xvga_timing_gen.sv
// XGA 1024x768@60 raster timing generator with a pixel-path output aligner.
// Optional test-pattern bars: define XVGA_TEST_PATTERN_EN.
module xvga_timing_gen #(
   parameter int H_ACTIVE   = 1024,
   parameter int H_FP       = 24,
   parameter int H_SYNC     = 136,
   parameter int H_BP       = 160,
   parameter int V_ACTIVE   = 768,
   parameter int V_FP       = 3,
   parameter int V_SYNC     = 6,
   parameter int V_BP       = 29,
   parameter int PIPE_DELAY = 2
) (
   input  logic        vclock,
   input  logic        reset,
   input  logic        test_mode,
   input  logic [23:0] pixel_in,
   output logic [10:0] hcount,
   output logic [9:0]  vcount,
   output logic        hsync,
   output logic        vsync,
   output logic        blank,
   output logic        frame_start,
   output logic        vblank_start,
   output logic [15:0] frame_count,
   output logic        vga_hsync,
   output logic        vga_vsync,
   output logic        vga_blank,
   output logic [23:0] vga_pixel
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
   localparam logic [10:0] H_VIS  = 11'(H_ACTIVE);
   localparam logic [10:0] HS_LO  = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_HI  = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0]  V_VIS  = 10'(V_ACTIVE);
   localparam logic [9:0]  VS_LO  = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  VS_HI  = 10'(V_ACTIVE + V_FP + V_SYNC);

`ifdef XVGA_TEST_PATTERN_EN
   localparam int DW = 6;
`else
   localparam int DW = 3;
`endif
   localparam logic [DW-1:0] TAP_RST = DW'(3'b111) << (DW - 3);

   logic [10:0]   r_hcount;
   logic [9:0]    r_vcount;
   logic          r_hsync;
   logic          r_vsync;
   logic          r_blank;
   logic          r_frame_start;
   logic          r_vblank_start;
   logic [15:0]   r_frame_count;
   logic          r_vga_hsync;
   logic          r_vga_vsync;
   logic          r_vga_blank;
   logic [23:0]   r_vga_pixel;

   logic          w_hwrap;
   logic [10:0]   w_hnext;
   logic [9:0]    w_vnext;
   logic          w_origin;
   logic [DW-1:0] w_src;
   logic [DW-1:0] w_tap;
   logic [23:0]   w_pix;

   always_comb begin
      w_hwrap  = (r_hcount == H_LAST);
      w_hnext  = w_hwrap ? 11'd0 : r_hcount + 11'd1;
      w_vnext  = r_vcount;
      if (w_hwrap)
         w_vnext = (r_vcount == V_LAST) ? 10'd0 : r_vcount + 10'd1;
      w_origin = (w_hnext == 11'd0) && (w_vnext == 10'd0);
   end

   // Flags are decoded from the next counts so they line up with them.
   always_ff @(posedge vclock) begin
      if (reset) begin
         r_hcount       <= H_LAST;
         r_vcount       <= V_LAST;
         r_hsync        <= 1'b1;
         r_vsync        <= 1'b1;
         r_blank        <= 1'b1;
         r_frame_start  <= 1'b0;
         r_vblank_start <= 1'b0;
         r_frame_count  <= 16'hFFFF;
      end else begin
         r_hcount       <= w_hnext;
         r_vcount       <= w_vnext;
         r_hsync        <= !(w_hnext >= HS_LO && w_hnext < HS_HI);
         r_vsync        <= !(w_vnext >= VS_LO && w_vnext < VS_HI);
         r_blank        <= (w_hnext >= H_VIS) || (w_vnext >= V_VIS);
         r_frame_start  <= w_origin;
         r_vblank_start <= (w_hnext == 11'd0) && (w_vnext == V_VIS);
         if (w_origin)
            r_frame_count <= r_frame_count + 16'd1;
      end
   end

`ifdef XVGA_TEST_PATTERN_EN
   assign w_src = {r_hsync, r_vsync, r_blank, r_hcount[9:7]};
`else
   assign w_src = {r_hsync, r_vsync, r_blank};
`endif

   generate
      if (PIPE_DELAY == 0) begin : g_nodly
         assign w_tap = w_src;
      end else begin : g_dly
         logic [DW-1:0] r_dl [PIPE_DELAY];
         always_ff @(posedge vclock) begin
            if (reset) begin
               for (int i = 0; i < PIPE_DELAY; i++)
                  r_dl[i] <= TAP_RST;
            end else begin
               r_dl[0] <= w_src;
               for (int i = 1; i < PIPE_DELAY; i++)
                  r_dl[i] <= r_dl[i-1];
            end
         end
         assign w_tap = r_dl[PIPE_DELAY-1];
      end
   endgenerate

`ifdef XVGA_TEST_PATTERN_EN
   logic [23:0] w_pat;
   assign w_pat = {{8{w_tap[2]}}, {8{w_tap[1]}}, {8{w_tap[0]}}};
   assign w_pix = test_mode ? w_pat : pixel_in;
`else
   logic w_unused;
   assign w_unused = test_mode;
   assign w_pix    = pixel_in;
`endif

   always_ff @(posedge vclock) begin
      if (reset) begin
         r_vga_hsync <= 1'b1;
         r_vga_vsync <= 1'b1;
         r_vga_blank <= 1'b1;
         r_vga_pixel <= 24'h0;
      end else begin
         r_vga_hsync <= w_tap[DW-1];
         r_vga_vsync <= w_tap[DW-2];
         r_vga_blank <= w_tap[DW-3];
         r_vga_pixel <= w_tap[DW-3] ? 24'h0 : w_pix;
      end
   end

   assign hcount       = r_hcount;
   assign vcount       = r_vcount;
   assign hsync        = r_hsync;
   assign vsync        = r_vsync;
   assign blank        = r_blank;
   assign frame_start  = r_frame_start;
   assign vblank_start = r_vblank_start;
   assign frame_count  = r_frame_count;
   assign vga_hsync    = r_vga_hsync;
   assign vga_vsync    = r_vga_vsync;
   assign vga_blank    = r_vga_blank;
   assign vga_pixel    = r_vga_pixel;

endmodule

// File: tb/tb_xvga_timing_gen.sv
// Bench for xvga_timing_gen: full XGA instance plus a tiny-raster instance
// (PIPE_DELAY=0) so whole frames fit in a short run.
module tb_xvga_timing_gen;

`ifdef XVGA_TEST_PATTERN_EN
   localparam bit PAT_EN = 1'b1;
`else
   localparam bit PAT_EN = 1'b0;
`endif

   typedef struct packed {
      logic [10:0] h;
      logic [9:0]  v;
      logic        hs;
      logic        vs;
      logic        bl;
      logic        fs;
      logic        vbs;
      logic [15:0] fc;
   } tim_t;

   typedef struct {
      int   n;
      bit   big;
      tim_t e;
   } vec_t;

   logic        vclock;
   logic        reset;
   logic        test_mode;
   logic [23:0] pixel_in;

   logic [10:0] b_h, s_h;
   logic [9:0]  b_v, s_v;
   logic        b_hs, b_vs, b_bl, b_fs, b_vbs;
   logic        s_hs, s_vs, s_bl, s_fs, s_vbs;
   logic [15:0] b_fc, s_fc;
   logic        b_phs, b_pvs, b_pbl, s_phs, s_pvs, s_pbl;
   logic [23:0] b_pix, s_pix;

   int nchk = 0;
   int nerr = 0;
   logic tm_q;
   tim_t qb[$];
   tim_t qs[$];
   vec_t vt[$];

   xvga_timing_gen dut_b (
      .vclock(vclock), .reset(reset), .test_mode(test_mode),
      .pixel_in(pixel_in),
      .hcount(b_h), .vcount(b_v), .hsync(b_hs), .vsync(b_vs),
      .blank(b_bl), .frame_start(b_fs), .vblank_start(b_vbs),
      .frame_count(b_fc),
      .vga_hsync(b_phs), .vga_vsync(b_pvs), .vga_blank(b_pbl),
      .vga_pixel(b_pix)
   );

   xvga_timing_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
      .V_ACTIVE(12), .V_FP(2), .V_SYNC(3), .V_BP(4),
      .PIPE_DELAY(0)
   ) dut_s (
      .vclock(vclock), .reset(reset), .test_mode(test_mode),
      .pixel_in(pixel_in),
      .hcount(s_h), .vcount(s_v), .hsync(s_hs), .vsync(s_vs),
      .blank(s_bl), .frame_start(s_fs), .vblank_start(s_vbs),
      .frame_count(s_fc),
      .vga_hsync(s_phs), .vga_vsync(s_pvs), .vga_blank(s_pbl),
      .vga_pixel(s_pix)
   );

   initial vclock = 1'b0;
   always #5 vclock = ~vclock;

   function automatic tim_t mkt(int h, int v, bit hs, bit vs, bit bl,
                                bit fs, bit vbs, int fc);
      tim_t t;
      t.h = 11'(h); t.v = 10'(v);
      t.hs = hs; t.vs = vs; t.bl = bl; t.fs = fs; t.vbs = vbs;
      t.fc = 16'(fc);
      return t;
   endfunction

   function automatic vec_t mkv(int n, bit big, tim_t e);
      vec_t x;
      x.n = n; x.big = big; x.e = e;
      return x;
   endfunction

   function automatic tim_t model(int n, int ha, int hf, int hsw, int hb,
                                  int va, int vf, int vsw, int vb);
      int ht, vtot, h, v;
      ht   = ha + hf + hsw + hb;
      vtot = va + vf + vsw + vb;
      h    = n % ht;
      v    = (n / ht) % vtot;
      return mkt(h, v,
                 !(h >= ha + hf && h < ha + hf + hsw),
                 !(v >= va + vf && v < va + vf + vsw),
                 (h >= ha) || (v >= va),
                 (h == 0) && (v == 0),
                 (h == 0) && (v == va),
                 n / (ht * vtot));
   endfunction

   function automatic tim_t mbig(int n);
      return model(n, 1024, 24, 136, 160, 768, 3, 6, 29);
   endfunction

   function automatic tim_t msml(int n);
      return model(n, 16, 2, 4, 3, 12, 2, 3, 4);
   endfunction

   function automatic logic [26:0] pin_exp(tim_t t, logic tm);
      logic [23:0] px;
      logic [2:0]  b;
      b  = t.h[9:7];
      px = 24'h123456;
      if (tm && PAT_EN)
         px = {{8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
      if (t.bl)
         px = 24'h0;
      return {t.hs, t.vs, t.bl, px};
   endfunction

   task automatic chk(string nm, int n, logic [63:0] act, logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s n=%0d got=%h expected=%h", nm, n, act, exp);
      end
   endtask

   task automatic tick();
      tm_q = test_mode;
      @(posedge vclock);
      #1;
   endtask

   task automatic prefill();
      tim_t f;
      f = mkt(0, 0, 1, 1, 1, 0, 0, 0);
      qb.delete();
      qs.delete();
      for (int i = 0; i < 3; i++) qb.push_back(f);
      qs.push_back(f);
   endtask

   task automatic check_reset(int tag);
      chk("rst_big", tag,
          64'({b_h, b_v, b_hs, b_vs, b_bl, b_fs, b_vbs, b_fc}),
          64'(mkt(1343, 805, 1, 1, 1, 0, 0, 16'hFFFF)));
      chk("rst_small", tag,
          64'({s_h, s_v, s_hs, s_vs, s_bl, s_fs, s_vbs, s_fc}),
          64'(mkt(24, 20, 1, 1, 1, 0, 0, 16'hFFFF)));
      chk("rst_pin_big", tag, 64'({b_phs, b_pvs, b_pbl, b_pix}),
          64'({3'b111, 24'h0}));
      chk("rst_pin_small", tag, 64'({s_phs, s_pvs, s_pbl, s_pix}),
          64'({3'b111, 24'h0}));
   endtask

   task automatic run(int cycles, bit first);
      tim_t bt, st, e;
      int   hs_fall, fs_last;
      logic prev_hs, prev_phs;
      hs_fall  = -1;
      fs_last  = -1;
      prev_hs  = 1'b1;
      prev_phs = 1'b1;
      for (int n = 0; n < cycles; n++) begin
         if (first && n == 1400) test_mode = 1'b1;
         if (first && n == 2800) test_mode = 1'b0;
         tick();
         bt = tim_t'({b_h, b_v, b_hs, b_vs, b_bl, b_fs, b_vbs, b_fc});
         st = tim_t'({s_h, s_v, s_hs, s_vs, s_bl, s_fs, s_vbs, s_fc});
         chk("big_timing", n, 64'(bt), 64'(mbig(n)));
         chk("small_timing", n, 64'(st), 64'(msml(n)));

         qb.push_back(mbig(n));
         e = qb.pop_front();
         chk("big_pins", n, 64'({b_phs, b_pvs, b_pbl, b_pix}),
             64'(pin_exp(e, tm_q)));
`ifdef XVGA_TEST_PATTERN_EN
         if (tm_q && !e.bl && e.h == 11'd384)
            chk("pat384", n, 64'(b_pix), 64'h00FFFF);
         if (tm_q && !e.bl && e.h == 11'd900)
            chk("pat900", n, 64'(b_pix), 64'hFFFFFF);
`endif
         qs.push_back(msml(n));
         e = qs.pop_front();
         chk("small_pins", n, 64'({s_phs, s_pvs, s_pbl, s_pix}),
             64'(pin_exp(e, tm_q)));

         if (first)
            foreach (vt[i])
               if (vt[i].n == n)
                  chk(vt[i].big ? "vec_big" : "vec_small", n,
                      vt[i].big ? 64'(bt) : 64'(st), 64'(vt[i].e));

         if (prev_hs && !b_hs) hs_fall = n;
         if (prev_phs && !b_phs && hs_fall >= 0)
            chk("pin_hsync_lag", n, 64'(n - hs_fall), 64'd3);
         prev_hs  = b_hs;
         prev_phs = b_phs;

         if (s_fs) begin
            if (fs_last >= 0)
               chk("fs_period", n, 64'(n - fs_last), 64'd525);
            fs_last = n;
         end
      end
   endtask

   initial begin
      vt.push_back(mkv(0,    1, mkt(0,    0, 1, 1, 0, 1, 0, 0)));
      vt.push_back(mkv(1023, 1, mkt(1023, 0, 1, 1, 0, 0, 0, 0)));
      vt.push_back(mkv(1024, 1, mkt(1024, 0, 1, 1, 1, 0, 0, 0)));
      vt.push_back(mkv(1047, 1, mkt(1047, 0, 1, 1, 1, 0, 0, 0)));
      vt.push_back(mkv(1048, 1, mkt(1048, 0, 0, 1, 1, 0, 0, 0)));
      vt.push_back(mkv(1183, 1, mkt(1183, 0, 0, 1, 1, 0, 0, 0)));
      vt.push_back(mkv(1184, 1, mkt(1184, 0, 1, 1, 1, 0, 0, 0)));
      vt.push_back(mkv(1343, 1, mkt(1343, 0, 1, 1, 1, 0, 0, 0)));
      vt.push_back(mkv(1344, 1, mkt(0,    1, 1, 1, 0, 0, 0, 0)));
      vt.push_back(mkv(0,    0, mkt(0,  0, 1, 1, 0, 1, 0, 0)));
      vt.push_back(mkv(16,   0, mkt(16, 0, 1, 1, 1, 0, 0, 0)));
      vt.push_back(mkv(18,   0, mkt(18, 0, 0, 1, 1, 0, 0, 0)));
      vt.push_back(mkv(300,  0, mkt(0, 12, 1, 1, 1, 0, 1, 0)));
      vt.push_back(mkv(349,  0, mkt(24, 13, 1, 1, 1, 0, 0, 0)));
      vt.push_back(mkv(350,  0, mkt(0, 14, 1, 0, 1, 0, 0, 0)));
      vt.push_back(mkv(424,  0, mkt(24, 16, 1, 0, 1, 0, 0, 0)));
      vt.push_back(mkv(425,  0, mkt(0, 17, 1, 1, 1, 0, 0, 0)));
      vt.push_back(mkv(524,  0, mkt(24, 20, 1, 1, 1, 0, 0, 0)));
      vt.push_back(mkv(525,  0, mkt(0,  0, 1, 1, 0, 1, 0, 1)));

      reset     = 1'b1;
      test_mode = 1'b0;
      pixel_in  = 24'h123456;
      repeat (5) tick();
      check_reset(-1);

      reset = 1'b0;
      prefill();
      run(7221, 1'b1);

      // Big raster at (500,5); small raster inside its vsync pulse.
      reset = 1'b1;
      tick();
      check_reset(-2);
      reset = 1'b0;
      prefill();
      run(600, 1'b0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
